od_line_tx: RTL and testbench

OD_LINE_TX -- requirements
Module: od_line_tx

---
 rtl/od_line_tx.sv | 188 ++++++++++++++++++
 tb/tb_od_line_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/od_line_tx.sv
// ---------------------------------------------------------------------------
// od_line_tx -- serial transmitter for a shared open-drain line.
//
// A word is accepted from a valid/ready handshake and shifted out MSB first.
// Each bit lasts BIT_CYCLES clocks and is followed by one stop period of the
// same length. The block only ever pulls the line low or releases it. The
// line is sampled on the last cycle of every period. If the line reads low
// while this block is releasing it, another driver has won. The transfer is
// then abandoned with an arb_lost pulse.
//
// Parameters
//   DATA_W      word width in bits (>= 2)
//   BIT_CYCLES  clocks per transmitted bit (>= 2; >= 3 with the synchronizer)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-high reset
//   tx_valid   in   word offered on tx_data
//   tx_data    in   word to send, MSB first
//   tx_ready   out  word can be accepted this cycle (IDLE and not in reset)
//   line_oe    out  1 = pull shared line low, 0 = release it
//   line_in    in   resolved value of the shared line
//   busy       out  transfer in progress
//   done       out  one-cycle pulse: word and stop period sent without loss
//   arb_lost   out  one-cycle pulse: line read low while released by us
//
// Build option
//   OD_LINE_TX_SYNC_EN  when defined, line_in passes through a two-flop
//                       synchronizer (reset to 1) before it is sampled.
// ---------------------------------------------------------------------------
module od_line_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              line_oe,
    input  logic              line_in,
    output logic              busy,
    output logic              done,
    output logic              arb_lost
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [DATA_W-1:0]  sh_q,    sh_d;
    logic               oe_q,    oe_d;
    logic               done_q,  done_d;
    logic               lost_q,  lost_d;

    // Value of the line as seen at the sample point.
    logic line_s;

`ifdef OD_LINE_TX_SYNC_EN
    logic sync1_q, sync2_q;

    // Both stages reset to 1 (released line), so reset never looks like a
    // remote driver holding the line low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
        end
    end

    assign line_s = sync2_q;
`else
    assign line_s = line_in;
`endif

    logic sample;
    logic loss;

    assign sample = (cnt_q == CNT_LAST);
    // Only a sample taken while we release the line can reveal a loss; when we
    // pull it low ourselves, a low reading is expected.
    assign loss   = sample && !oe_q && !line_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        oe_d    = oe_q;
        done_d  = 1'b0;
        lost_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d = DATA;
                    sh_d    = tx_data;
                    oe_d    = ~tx_data[DATA_W-1];
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end

            DATA: begin
                cnt_d = sample ? '0 : cnt_q + CNT_W'(1);
                if (loss) begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                    lost_d  = 1'b1;
                    idx_d   = '0;
                end else if (sample) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                        oe_d    = 1'b0;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        sh_d  = sh_q << 1;
                        // The next bit sits just below the current MSB.
                        oe_d  = ~sh_q[DATA_W-2];
                    end
                end
            end

            STOP: begin
                cnt_d = sample ? '0 : cnt_q + CNT_W'(1);
                oe_d  = 1'b0;
                if (loss) begin
                    state_d = IDLE;
                    lost_d  = 1'b1;
                end else if (sample) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                oe_d    = 1'b0;
            end
        endcase
    end

    // The asynchronous reset clears oe_q immediately. Reset therefore releases
    // the line mid-transfer without waiting for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
            lost_q  <= lost_d;
        end
    end

    assign tx_ready = (state_q == IDLE) && !rst;
    assign busy     = (state_q != IDLE);
    assign line_oe  = oe_q;
    assign done     = done_q;
    assign arb_lost = lost_q;

endmodule

// File: tb/tb_od_line_tx.sv
module tb_od_line_tx;

    localparam int DW = 8;
    localparam int BC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_ready, line_oe, line_in, busy, done, arb_lost;
    logic          force_low = 1'b0;

    // Open-drain line with pull-up; force_low models another driver.
    assign line_in = ~(line_oe | force_low);

    od_line_tx #(.DATA_W(DW), .BIT_CYCLES(BC)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .line_oe  (line_oe),
        .line_in  (line_in),
        .busy     (busy),
        .done     (done),
        .arb_lost (arb_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_done;
        int          lat;
        logic [63:0] exp;
        logic [63:0] mask;
    } exp_t;

    exp_t q[$];
    exp_t e_m;

    int          acc_cyc = 0;
    int          acc_cnt = 0;
    bit          active  = 0;
    logic [63:0] hist    = '0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic chkv(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Expected line_oe per cycle offset k after acceptance: bit (k-1)/BC is
    // driven inverted for k = 1..DW*BC, then the stop period is released.
    function automatic exp_t mk(input bit is_done, input logic [DW-1:0] w, input int lat);
        exp_t e;
        e.is_done = is_done;
        e.lat     = lat;
        e.exp     = '0;
        e.mask    = '0;
        for (int k = 1; k < lat; k++) begin
            e.mask[k] = 1'b1;
            if (k <= DW * BC) e.exp[k] = ~w[DW - 1 - (k - 1) / BC];
        end
        return e;
    endfunction

    // Monitor: records line_oe history per transfer and checks it against the
    // queued expectation whenever a done or arb_lost pulse appears.
    always @(negedge clk) begin
        if (rst) begin
            active = 0;
        end else begin
            if (active && busy && (cyc - acc_cyc) < 64) hist[cyc - acc_cyc] = line_oe;
            if (done || arb_lost) begin
                chk("pulse_exclusive", int'(done && arb_lost), 0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got done=%0b arb_lost=%0b expected none", done, arb_lost);
                end else begin
                    e_m = q.pop_front();
                    chk("pulse_kind_done", int'(done), int'(e_m.is_done));
                    chk("pulse_latency", cyc - acc_cyc, e_m.lat);
                    chkv("line_oe_pattern", hist & e_m.mask, e_m.exp & e_m.mask);
                    if (arb_lost) begin
                        chk("lost_busy", int'(busy), 0);
                        chk("lost_line_oe", int'(line_oe), 0);
                    end
                end
                active = 0;
            end
            if (tx_valid && tx_ready) begin
                active  = 1;
                acc_cyc = cyc;
                hist    = '0;
                acc_cnt++;
            end
        end
    end

    // Offer a word; returns 1 ns into cycle N+1 with tx_valid dropped.
    task automatic start(input logic [DW-1:0] w);
        int n0;
        int t;
        n0 = acc_cnt;
        t  = 0;
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data  = w;
        while (acc_cnt == n0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (acc_cnt == n0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept of %h", w);
        end
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 200);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_line_oe", int'(line_oe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_arb_lost", int'(arb_lost), 0);
        chk("rst_tx_ready", int'(tx_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(tx_ready), 1);

        // Plain word, full transfer
        q.push_back(mk(1, 8'hA5, 37));
        start(8'hA5);
        wait_idle();

        // 0xFF with line held low through bit 3: lost at N+17
        q.push_back(mk(0, 8'hFF, 17));
        start(8'hFF);
        repeat (12) @(posedge clk);
        #1 force_low = 1'b1;
        repeat (4) @(posedge clk);
        #1 force_low = 1'b0;
        wait_idle();

        // Low line while we pull low ourselves is never a loss
        q.push_back(mk(1, 8'h0F, 37));
        start(8'h0F);
        repeat (4) @(posedge clk);
        #1 force_low = 1'b1;
        repeat (4) @(posedge clk);
        #1 force_low = 1'b0;
        wait_idle();

        // Line low only in the bit-3 sample cycle (N+16)
`ifdef OD_LINE_TX_SYNC_EN
        q.push_back(mk(1, 8'hFF, 37));
`else
        q.push_back(mk(0, 8'hFF, 17));
`endif
        start(8'hFF);
        repeat (15) @(posedge clk);
        #1 force_low = 1'b1;
        @(posedge clk);
        #1 force_low = 1'b0;
        wait_idle();

        // Line low only 2 cycles before the bit-3 sample (N+14)
`ifdef OD_LINE_TX_SYNC_EN
        q.push_back(mk(0, 8'hFF, 17));
`else
        q.push_back(mk(1, 8'hFF, 37));
`endif
        start(8'hFF);
        repeat (13) @(posedge clk);
        #1 force_low = 1'b1;
        @(posedge clk);
        #1 force_low = 1'b0;
        wait_idle();

        // Back-to-back: tx_valid held, second word taken in the done cycle
        q.push_back(mk(1, 8'h3C, 37));
        q.push_back(mk(1, 8'hC3, 37));
        start(8'h3C);
        a0 = acc_cyc;
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        begin
            int t;
            t = 0;
            while (acc_cnt < 2 + 5 && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
        end
        tx_valid = 1'b0;
        chk("b2b_accept_gap", acc_cyc - a0, 37);
        wait_idle();

        // Input activity while busy is ignored
        q.push_back(mk(1, 8'hA5, 37));
        start(8'hA5);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = 8'($urandom);
        end
        tx_valid = 1'b0;
        wait_idle();

        // Reset during bit 5 releases the line without an edge
        start(8'h00);
        repeat (21) @(posedge clk);
        #1;
        chk("bit5_line_oe_before_rst", int'(line_oe), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_line_oe", int'(line_oe), 0);
        chk("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        chk("rst_mid_tx_ready", int'(tx_ready), 0);
        chk("rst_mid_done", int'(done), 0);
        chk("rst_mid_arb_lost", int'(arb_lost), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_mid_rst", int'(tx_ready), 1);

        repeat (10) @(posedge clk);
        chk("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
